// File: rtl/updown_modn_pkg.sv
// Shared mode encodings and bounce-state type for the up/down modulo-N counter.
package updown_modn_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    BNC_UP = 1'b0,
    BNC_DN = 1'b1
  } bnc_state_e;

  localparam logic [6:0] SEG7_DIGIT_ZERO = 7'b0111111;

endpackage

// File: rtl/updown_modn_counter_seg7_hex_dec.sv
// Combinational hex digit to active-high gfedcba seven-segment pattern.
// Zero latency, no flow control.
module seg7_hex_dec (
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  always_comb begin
    segs = 7'b0000000;
    case (hex)
      4'h0: segs = 7'b0111111;
      4'h1: segs = 7'b0000110;
      4'h2: segs = 7'b1011011;
      4'h3: segs = 7'b1001111;
      4'h4: segs = 7'b1100110;
      4'h5: segs = 7'b1101101;
      4'h6: segs = 7'b1111101;
      4'h7: segs = 7'b0000111;
      4'h8: segs = 7'b1111111;
      4'h9: segs = 7'b1101111;
      4'ha: segs = 7'b1110111;
      4'hb: segs = 7'b1111100;
      4'hc: segs = 7'b0111001;
      4'hd: segs = 7'b1011110;
      4'he: segs = 7'b1111001;
      4'hf: segs = 7'b1110001;
      default: segs = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/updown_modn_counter.sv
// Up/down/hold/bounce modulo-MODULUS counter; count, dir_down and tc are registered (1-cycle latency).
// Optional seven-segment output of the count is compiled in with UPDOWN_MODN_SEG7_EN.
module updown_modn_counter
  import updown_modn_pkg::*;
#(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir_down,
  output logic             tc
`ifdef UPDOWN_MODN_SEG7_EN
  ,
  output logic [6:0]       segs
`endif
);

  if (MODULUS < 2) begin : g_bad_modulus
    $error("updown_modn_counter: MODULUS must be >= 2");
  end
  if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
    $error("updown_modn_counter: WIDTH too small for MODULUS");
  end

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PRE_MAX = WIDTH'(MODULUS - 2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  bnc_state_e       state_q, state_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      state_q <= BNC_UP;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if ({1'b0, count_q} >= MOD_EXT) begin
      count_d = '0;
      state_d = BNC_UP;
    end else if (load) begin
      count_d = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_CNT;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_UP: begin
          state_d = BNC_UP;
          if (count_q == MAX_CNT) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
        MODE_DOWN: begin
          state_d = BNC_DN;
          if (count_q == '0) begin
            count_d = MAX_CNT;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - ONE;
          end
        end
        MODE_HOLD: begin
          count_d = count_q;
        end
        MODE_BOUNCE: begin
          // Entering at the far end in the wrong direction turns around silently.
          if (state_q == BNC_UP) begin
            if (count_q == MAX_CNT) begin
              count_d = count_q - ONE;
              state_d = BNC_DN;
            end else begin
              count_d = count_q + ONE;
              if (count_q == PRE_MAX) begin
                state_d = BNC_DN;
                tc_d    = 1'b1;
              end
            end
          end else begin
            if (count_q == '0) begin
              count_d = ONE;
              state_d = BNC_UP;
            end else begin
              count_d = count_q - ONE;
              if (count_q == ONE) begin
                state_d = BNC_UP;
                tc_d    = 1'b1;
              end
            end
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    count    = count_q;
    dir_down = (state_q == BNC_DN);
    tc       = tc_q;
  end

`ifdef UPDOWN_MODN_SEG7_EN
  logic [3:0] seg_nib;
  always_comb seg_nib = 4'(count_q);

  seg7_hex_dec u_seg7 (
    .hex  (seg_nib),
    .segs (segs)
  );
`endif

endmodule

// File: tb/tb_updown_modn_counter.sv
// Randomized and directed bench for updown_modn_counter at MODULUS=6 and MODULUS=2.
module tb_updown_modn_counter;
  import updown_modn_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, load;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       dir_down, tc;
  logic [1:0] count2;
  logic       dir2, tc2;
`ifdef UPDOWN_MODN_SEG7_EN
  logic [6:0] segs, segs2;
  logic [6:0] seg_tbl [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                               7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
`endif

  updown_modn_counter #(.MODULUS(6), .WIDTH(4)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .count(count), .dir_down(dir_down), .tc(tc)
`ifdef UPDOWN_MODN_SEG7_EN
    , .segs(segs)
`endif
  );

  updown_modn_counter #(.MODULUS(2), .WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val[1:0]),
    .count(count2), .dir_down(dir2), .tc(tc2)
`ifdef UPDOWN_MODN_SEG7_EN
    , .segs(segs2)
`endif
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int m_cnt, m2_cnt;
  bit m_dir, m_tc, m2_dir, m2_tc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Counter behaviour expressed as modular arithmetic plus the bounce turn-around rules.
  function automatic void model_step(input int m, input logic e, input logic [1:0] md,
                                     input logic ld, input int lv,
                                     inout int c, inout bit d, inout bit t);
    t = 1'b0;
    if (ld) begin
      c = (lv < m) ? lv : m - 1;
    end else if (e) begin
      case (md)
        2'b00: begin c = (c + 1) % m; t = (c == 0); d = 1'b0; end
        2'b01: begin c = (c + m - 1) % m; t = (c == m - 1); d = 1'b1; end
        2'b10: ;
        default: begin
          if (!d) begin
            if (c == m - 1) begin c = c - 1; d = 1'b1; end
            else begin c = c + 1; if (c == m - 1) begin d = 1'b1; t = 1'b1; end end
          end else begin
            if (c == 0) begin c = c + 1; d = 1'b0; end
            else begin c = c - 1; if (c == 0) begin d = 1'b0; t = 1'b1; end end
          end
        end
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".cnt"}, 32'(count), 32'(m_cnt));
    chk({tag, ".dir"}, 32'(dir_down), 32'(m_dir));
    chk({tag, ".tc"}, 32'(tc), 32'(m_tc));
    chk({tag, ".cnt2"}, 32'(count2), 32'(m2_cnt));
    chk({tag, ".dir2"}, 32'(dir2), 32'(m2_dir));
    chk({tag, ".tc2"}, 32'(tc2), 32'(m2_tc));
`ifdef UPDOWN_MODN_SEG7_EN
    chk({tag, ".segs"}, 32'(segs), 32'(seg_tbl[m_cnt]));
    chk({tag, ".segs2"}, 32'(segs2), 32'(seg_tbl[m2_cnt]));
`endif
  endtask

  task automatic step(input logic e, input logic [1:0] md, input logic ld,
                      input logic [3:0] lv, input string tag);
    en = e; mode = md; load = ld; load_val = lv;
    @(posedge clk);
    model_step(6, e, md, ld, int'(lv), m_cnt, m_dir, m_tc);
    model_step(2, e, md, ld, int'(lv[1:0]), m2_cnt, m2_dir, m2_tc);
    #1;
    check_all(tag);
  endtask

  // Pulses reset between clock edges and checks the asynchronous clear.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    m_cnt = 0; m_dir = 0; m_tc = 0;
    m2_cnt = 0; m2_dir = 0; m2_tc = 0;
    #1;
    check_all(tag);
`ifdef UPDOWN_MODN_SEG7_EN
    chk({tag, ".seg0"}, 32'(segs), 32'(SEG7_DIGIT_ZERO));
`endif
    #1 reset = 1'b0;
  endtask

  initial begin
    int exp_up [7]    = '{1, 2, 3, 4, 5, 0, 1};
    int exp_dn [3]    = '{5, 4, 3};
    int exp_bnc [12]  = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = MODE_UP; load_val = '0;
    m_cnt = 0; m_dir = 0; m_tc = 0;
    m2_cnt = 0; m2_dir = 0; m2_tc = 0;
    #2;
    check_all("reset");
    #2 reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      step(1'b1, MODE_UP, 1'b0, 4'd0, "up");
      chk("up_seq", 32'(count), 32'(exp_up[i]));
      chk("up_tc", 32'(tc), (i == 5) ? 32'd1 : 32'd0);
    end

    do_reset("rst_a");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, MODE_DOWN, 1'b0, 4'd0, "down");
      chk("down_seq", 32'(count), 32'(exp_dn[i]));
      chk("down_tc", 32'(tc), (i == 0) ? 32'd1 : 32'd0);
      chk("down_dir", 32'(dir_down), 32'd1);
    end

    do_reset("rst_b");
    for (int i = 0; i < 12; i++) begin
      step(1'b1, MODE_BOUNCE, 1'b0, 4'd0, "bnc");
      chk("bnc_seq", 32'(count), 32'(exp_bnc[i]));
      chk("bnc_tc", 32'(tc), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      chk("bnc2_tc", 32'(tc2), 32'd1);
    end

    step(1'b1, MODE_UP, 1'b1, 4'd9, "load_sat");
    chk("load_sat_cnt", 32'(count), 32'd5);
    chk("load_sat_tc", 32'(tc), 32'd0);
    step(1'b1, MODE_UP, 1'b0, 4'd0, "load_wrap");
    chk("load_wrap_cnt", 32'(count), 32'd0);
    chk("load_wrap_tc", 32'(tc), 32'd1);

    step(1'b1, MODE_DOWN, 1'b0, 4'd0, "pre_bdn");
    step(1'b1, MODE_BOUNCE, 1'b0, 4'd0, "pre_bdn");
    step(1'b1, MODE_BOUNCE, 1'b0, 4'd0, "pre_bdn");
    chk("bdn_cnt", 32'(count), 32'd3);
    chk("bdn_dir", 32'(dir_down), 32'd1);
    do_reset("rst_mid");
    chk("rst_mid_cnt", 32'(count), 32'd0);
    chk("rst_mid_dir", 32'(dir_down), 32'd0);
    step(1'b1, MODE_BOUNCE, 1'b0, 4'd0, "post_rst");
    chk("post_rst_cnt", 32'(count), 32'd1);

    step(1'b0, MODE_UP, 1'b1, 4'd4, "load4");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'($urandom_range(0, 3)), 1'b0, 4'($urandom_range(0, 15)), "en0");
      chk("en0_cnt", 32'(count), 32'd4);
      chk("en0_tc", 32'(tc), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_modn_counter.md
UPDOWN_MODN_COUNTER -- requirements
Module: updown_modn_counter

Interface
REQ-001 Parameter: MODULUS, 6, count range 0..MODULUS-1; SHALL be >= 2.
REQ-002 Parameter: WIDTH, 4, count width; SHALL satisfy 2**WIDTH >= MODULUS, else elaboration error.
REQ-003 Port: clk  input  1  clock, rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: en  input  1  count enable.
REQ-006 Port: mode  input  2  00 UP, 01 DOWN, 10 HOLD, 11 BOUNCE.
REQ-007 Port: load  input  1  synchronous load strobe.
REQ-008 Port: load_val  input  WIDTH  value to load.
REQ-009 Port: count  output  WIDTH  registered count.
REQ-010 Port: dir_down  output  1  registered direction flag (1 = counting down).
REQ-011 Port: tc  output  1  registered terminal-count pulse, one cycle.
REQ-012 Port: segs  output  7  active-high gfedcba pattern of count (present only with UPDOWN_MODN_SEG7_EN).

Function
REQ-013 Priority per rising edge: load > en; en=0 and load=0 -> count, dir_down hold; tc=0.
REQ-014 Load: count <= load_val if load_val < MODULUS, else MODULUS-1 (saturate); dir_down unchanged; tc=0.
REQ-015 UP (en=1): count+1; MODULUS-1 -> 0 wrap with tc=1 that cycle; dir_down <= 0.
REQ-016 DOWN (en=1): count-1; 0 -> MODULUS-1 wrap with tc=1 that cycle; dir_down <= 1.
REQ-017 HOLD (en=1): count, dir_down unchanged; tc=0.
REQ-018 BOUNCE FSM, states BNC_UP (dir_down=0) / BNC_DN (dir_down=1): BNC_UP increments, BNC_DN decrements.
REQ-019 BNC_UP at count=MODULUS-2 -> count MODULUS-1, state BNC_DN, tc=1; BNC_DN at count=1 -> count 0, state BNC_UP, tc=1.
REQ-020 BOUNCE entered with count=MODULUS-1 and dir_down=0 -> decrement, dir_down <= 1, tc=0; entered with count=0 and dir_down=1 -> increment, dir_down <= 0, tc=0.
REQ-021 BOUNCE entry state taken from current dir_down (mode switches carry direction).
REQ-022 MODULUS=2 in BOUNCE: sequence 0,1,0,1 with tc=1 every enabled cycle.
REQ-023 Out-of-range count (>= MODULUS) on any edge SHALL recover to 0, dir_down 0, tc 0.
REQ-024 All arithmetic in WIDTH bits; no intermediate overflow visible on count.

Reset
REQ-025 reset=1 asynchronously forces count=0, dir_down=0, tc=0, independent of clk.
REQ-026 Reset mid-operation aborts any load/bounce; first edge after release behaves as from count=0, BNC_UP.
REQ-027 segs during reset SHALL read 7'b0111111 (digit 0) when compiled in.

Configuration
REQ-028 Macro UPDOWN_MODN_SEG7_EN defined: segs port present, combinational hex decode of count[3:0] (0-9, A, b, C, d, E, F).
REQ-029 Macro undefined: segs port and decoder absent; all other behaviour identical.

Structure
REQ-030 Package updown_modn_pkg SHALL hold mode encodings (MODE_UP, MODE_DOWN, MODE_HOLD, MODE_BOUNCE) and BOUNCE state typedef.
REQ-031 Sub-module seg7_hex_dec (4-bit in, 7-bit gfedcba out) instantiated only under UPDOWN_MODN_SEG7_EN.

Verification
REQ-032 MODULUS=6, UP, en=1, 7 edges from reset -> count 1,2,3,4,5,0,1; tc=1 only on the edge to 0.
REQ-033 MODULUS=6, DOWN, en=1 from 0 -> count 5,4,3; tc=1 on edge to 5; dir_down=1.
REQ-034 MODULUS=6, BOUNCE, 12 edges from 0 -> 1,2,3,4,5,4,3,2,1,0,1,2; tc=1 at 5 and 0.
REQ-035 load=1, load_val=9, en=1, MODULUS=6 -> count=5, tc=0; next edge UP -> 0, tc=1.
REQ-036 reset asserted between edges at count=3 in BNC_DN -> count=0, dir_down=0 immediately; segs=7'b0111111 with SEG7_EN.
REQ-037 en=0 for 3 edges at count=4, any mode -> count stays 4, tc=0.
